// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, instruction field positions,
// opcode constants used by the control unit, and the memory-latency range rule.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } fetch_state_e;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int SH_HI  = 10;
  localparam int SH_LO  = 6;
  localparam int FN_HI  = 5;
  localparam int FN_LO  = 0;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;
  localparam int JA_HI  = 25;
  localparam int JA_LO  = 0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 15;
  localparam int CNT_W       = 4;

  function automatic bit mem_lat_legal(input int lat);
    return (lat >= MEM_LAT_MIN) && (lat <= MEM_LAT_MAX);
  endfunction

endpackage

// File: rtl/ir_fields.sv
// Combinational splitter of an instruction word into its decode fields.
module ir_fields
  import cpu_pkg::*;
(
  input  logic [31:0] ir_i,
  output logic [5:0]  opcode_o,
  output logic [4:0]  rs_o,
  output logic [4:0]  rt_o,
  output logic [4:0]  rd_o,
  output logic [4:0]  shamt_o,
  output logic [5:0]  funct_o,
  output logic [15:0] imm16_o,
  output logic [25:0] jaddr_o
);

  assign opcode_o = ir_i[OPC_HI:OPC_LO];
  assign rs_o     = ir_i[RS_HI:RS_LO];
  assign rt_o     = ir_i[RT_HI:RT_LO];
  assign rd_o     = ir_i[RD_HI:RD_LO];
  assign shamt_o  = ir_i[SH_HI:SH_LO];
  assign funct_o  = ir_i[FN_HI:FN_LO];
  assign imm16_o  = ir_i[IMM_HI:IMM_LO];
  assign jaddr_o  = ir_i[JA_HI:JA_LO];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues a fixed-latency memory read at the latched PC,
// loads the instruction register and presents decoded fields, PC+4 and a misalign flag.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int          MEM_LAT  = 2,
  parameter logic [31:0] RESET_IR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic        flush,
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic [31:0] ir_out,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm16,
  output logic [25:0] jaddr,
  output logic [31:0] pc_plus4,
  output logic        ir_valid,
  output logic        fetch_busy,
  output logic        fetch_done,
  output logic        misalign
);

  if (!mem_lat_legal(MEM_LAT)) begin : g_bad_mem_lat
    $error("fetch_unit: MEM_LAT must be within 1..15");
  end

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  fetch_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      pc4_q, pc4_d;
  logic [31:0]      ir_q, ir_d;
  logic             valid_q, valid_d;
  logic             mis_q, mis_d;

  // NOTE: every next-state signal gets a hold default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    pc4_d   = pc4_q;
    ir_d    = ir_q;
    valid_d = valid_q;
    mis_d   = mis_q;

    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        WAIT: begin
          if (cnt_q == '0) begin
            ir_d    = mem_rdata;
            valid_d = 1'b1;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          if (fetch_req) begin
            if (pc_in[1:0] == 2'b00) begin
              addr_d  = pc_in;
              pc4_d   = pc_in + 32'd4;
              cnt_d   = CNT_LOAD;
              mis_d   = 1'b0;
              state_d = WAIT;
            end else begin
              mis_d = 1'b1;
            end
          end
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      pc4_q   <= 32'd4;
      ir_q    <= RESET_IR;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      pc4_q   <= pc4_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
    end
  end

  // Strobes decode registered state only, so no input can glitch them.
  assign mem_rd     = (state_q == WAIT);
  assign fetch_busy = (state_q == WAIT);
  assign fetch_done = (state_q == DONE);
  assign mem_addr   = addr_q;
  assign pc_plus4   = pc4_q;
  assign ir_out     = ir_q;
  assign ir_valid   = valid_q;
  assign misalign   = mis_q;

  ir_fields u_ir_fields (
    .ir_i     (ir_q),
    .opcode_o (opcode),
    .rs_o     (rs),
    .rt_o     (rt),
    .rd_o     (rd),
    .shamt_o  (shamt),
    .funct_o  (funct),
    .imm16_o  (imm16),
    .jaddr_o  (jaddr)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized and directed bench for fetch_unit against a cycle-count reference model.
module tb_fetch_unit;

  localparam int          MEM_LAT  = 2;
  localparam logic [31:0] RESET_IR = 32'h1234_5678;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic        flush;
  logic [31:0] pc_in;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [31:0] ir_out;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [15:0] imm16;
  logic [25:0] jaddr;
  logic [31:0] pc_plus4;
  logic        ir_valid, fetch_busy, fetch_done, misalign;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: remaining read cycles instead of FSM states.
  int          m_busy;
  bit          m_done;
  bit          m_valid;
  bit          m_mis;
  logic [31:0] m_ir;
  logic [31:0] m_addr;

  always #5 clk = ~clk;

  fetch_unit #(.MEM_LAT(MEM_LAT), .RESET_IR(RESET_IR)) dut (
    .clk        (clk),
    .reset      (reset),
    .fetch_req  (fetch_req),
    .flush      (flush),
    .pc_in      (pc_in),
    .mem_rdata  (mem_rdata),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .ir_out     (ir_out),
    .opcode     (opcode),
    .rs         (rs),
    .rt         (rt),
    .rd         (rd),
    .shamt      (shamt),
    .funct      (funct),
    .imm16      (imm16),
    .jaddr      (jaddr),
    .pc_plus4   (pc_plus4),
    .ir_valid   (ir_valid),
    .fetch_busy (fetch_busy),
    .fetch_done (fetch_done),
    .misalign   (misalign)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy  = 0;
    m_done  = 1'b0;
    m_valid = 1'b0;
    m_mis   = 1'b0;
    m_ir    = RESET_IR;
    m_addr  = 32'd0;
  endtask

  task automatic model_edge(input bit req, input bit fl, input logic [31:0] pc,
                            input logic [31:0] rdata);
    logic [1:0] low;
    low = pc[1:0];
    if (fl) begin
      m_busy  = 0;
      m_done  = 1'b0;
      m_valid = 1'b0;
    end else if (m_busy > 0) begin
      if (m_busy == 1) begin
        m_ir    = rdata;
        m_valid = 1'b1;
        m_done  = 1'b1;
      end
      m_busy--;
    end else begin
      m_done = 1'b0;
      if (req) begin
        if (low == 2'b00) begin
          m_addr = pc;
          m_busy = MEM_LAT;
          m_mis  = 1'b0;
        end else begin
          m_mis = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all();
    bit busy;
    busy = (m_busy > 0);
    check("mem_rd",     32'(mem_rd),     32'(busy));
    check("fetch_busy", 32'(fetch_busy), 32'(busy));
    check("fetch_done", 32'(fetch_done), 32'(m_done));
    check("ir_valid",   32'(ir_valid),   32'(m_valid));
    check("misalign",   32'(misalign),   32'(m_mis));
    check("mem_addr",   mem_addr,        m_addr);
    check("pc_plus4",   pc_plus4,        m_addr + 32'd4);
    check("ir_out",     ir_out,          m_ir);
    check("opcode",     32'(opcode),     m_ir >> 26);
    check("rs",         32'(rs),         (m_ir >> 21) & 32'h1F);
    check("rt",         32'(rt),         (m_ir >> 16) & 32'h1F);
    check("rd",         32'(rd),         (m_ir >> 11) & 32'h1F);
    check("shamt",      32'(shamt),      (m_ir >> 6) & 32'h1F);
    check("funct",      32'(funct),      m_ir & 32'h3F);
    check("imm16",      32'(imm16),      m_ir & 32'hFFFF);
    check("jaddr",      32'(jaddr),      m_ir & 32'h03FF_FFFF);
  endtask

  // One clock: drive at negedge, memory returns `word` only on the final read cycle.
  task automatic step(input bit req, input bit fl, input logic [31:0] pc, input logic [31:0] word);
    @(negedge clk);
    fetch_req = req;
    flush     = fl;
    pc_in     = pc;
    mem_rdata = (m_busy == 1) ? word : $urandom;
    @(posedge clk);
    model_edge(req, fl, pc, mem_rdata);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, $urandom, $urandom);
  endtask

  initial begin
    int done_cnt;
    reset     = 1'b0;
    fetch_req = 1'b0;
    flush     = 1'b0;
    pc_in     = 32'd0;
    mem_rdata = 32'd0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    reset = 1'b1;
    idle(1);

    // single fetch
    step(1'b1, 1'b0, 32'h0000_0040, 32'h8C22_0004);
    check("single_rd_1", 32'(mem_rd), 32'd1);
    step(1'b0, 1'b0, 32'h0000_0100, 32'h8C22_0004);
    check("single_addr", mem_addr, 32'h0000_0040);
    step(1'b0, 1'b0, 32'h0000_0100, 32'h8C22_0004);
    check("single_ir",     ir_out,          32'h8C22_0004);
    check("single_opcode", 32'(opcode),     32'h23);
    check("single_rs",     32'(rs),         32'd1);
    check("single_rt",     32'(rt),         32'd2);
    check("single_imm",    32'(imm16),      32'd4);
    check("single_pc4",    pc_plus4,        32'h0000_0044);
    check("single_done",   32'(fetch_done), 32'd1);
    idle(1);
    check("single_done_pulse", 32'(fetch_done), 32'd0);

    // back-to-back: request held for 10 cycles
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 32'h0000_0100 + 32'(i * 4), $urandom);
      if (fetch_done) done_cnt++;
    end
    check("b2b_done_count", 32'(done_cnt), 32'd3);
    idle(4);

    // flush on the final WAIT cycle
    step(1'b1, 1'b0, 32'h0000_0200, $urandom);
    step(1'b0, 1'b0, 32'h0000_0200, $urandom);
    step(1'b0, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF);
    check("flush_valid", 32'(ir_valid),   32'd0);
    check("flush_done",  32'(fetch_done), 32'd0);
    check("flush_busy",  32'(fetch_busy), 32'd0);
    // flush together with a request
    step(1'b1, 1'b1, 32'h0000_0300, $urandom);
    check("flush_req_rd", 32'(mem_rd), 32'd0);
    idle(2);

    // misaligned request, then an aligned one
    step(1'b1, 1'b0, 32'h0000_0042, $urandom);
    check("mis_flag", 32'(misalign), 32'd1);
    check("mis_rd",   32'(mem_rd),   32'd0);
    step(1'b1, 1'b0, 32'h0000_0044, $urandom);
    check("mis_clear", 32'(misalign), 32'd0);
    idle(3);

    // wrap-around of PC+4
    step(1'b1, 1'b0, 32'hFFFF_FFFC, $urandom);
    check("wrap_pc4", pc_plus4, 32'h0000_0000);
    idle(3);

    // asynchronous reset during the first WAIT cycle
    step(1'b1, 1'b0, 32'h0000_0080, $urandom);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check("rst_ir", ir_out, RESET_IR);
    check_all();
    @(negedge clk);
    fetch_req = 1'b0;
    flush     = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    idle(4);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      bit          req, fl;
      int          sel;
      logic [31:0] pc;
      req = ($urandom_range(0, 9) < 6);
      fl  = ($urandom_range(0, 99) < 8);
      sel = $urandom_range(0, 9);
      pc  = $urandom;
      if (sel == 0)      pc = 32'hFFFF_FFFC;
      else if (sel <= 2) pc = {pc[31:2], 2'(1 + $urandom_range(0, 2))};
      else               pc = {pc[31:2], 2'b00};
      step(req, fl, pc, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
